// File: rtl/led_mux_scan_ctrl_pkg.sv
// led_mux_scan_ctrl_pkg: FSM encodings, display constants and sizing helpers
// shared by the 7-segment scan controller and its timer.
package led_mux_scan_ctrl_pkg;
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_LOAD  = 3'd2;
    localparam logic [2:0] ST_SHOW  = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;
    localparam logic [7:0] SSEG_OFF = 8'hFF;

    function automatic int f_clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

    function automatic int f_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/led_mux_scan_ctrl_timer.sv
// led_mux_scan_ctrl_timer: loadable down-counter; done is high while the count is 1,
// so a phase loaded with N lasts exactly N cycles.
module led_mux_scan_ctrl_timer #(
    parameter int TW = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          i_load,
    input  logic [TW-1:0] i_load_val,
    output logic          o_done
);
    logic [TW-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_cnt <= '0;
        else if (i_load) r_cnt <= i_load_val;
        else if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
    end

    assign o_done = r_cnt == TW'(1);
endmodule

// File: rtl/led_mux_scan_ctrl.sv
// led_mux_scan_ctrl: multiplexed 7-segment scanner driving an external synchronous
// pattern ROM, with per-frame input snapshot and an anode blanking gap between digits.
module led_mux_scan_ctrl
    import led_mux_scan_ctrl_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int SHOW_CYC = 50000,
    parameter int GAP_CYC  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [4*N_DIGITS-1:0] hex_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic [N_DIGITS-1:0]   blank_in,
    output logic [3:0]            rom_addr,
    input  logic [6:0]            rom_data,
    output logic [N_DIGITS-1:0]   an,
    output logic [7:0]            sseg,
    output logic                  frame_tick
);
    localparam int TW = f_clog2(f_max(SHOW_CYC, GAP_CYC) + 1);
    localparam int SW = f_clog2(N_DIGITS);

    logic [2:0]            r_state, w_state_nxt;
    logic [SW-1:0]         r_sel;
    logic [4*N_DIGITS-1:0] r_snap_hex;
    logic [N_DIGITS-1:0]   r_snap_dp, r_snap_blank, r_an;
    logic [7:0]            r_sseg;
    logic                  r_frame_tick;
    logic                  w_gap_en, w_last, w_show_done, w_to_fetch, w_new_frame;
    logic                  w_tmr_load, w_tmr_done;
    logic [TW-1:0]         w_tmr_val;

    assign w_gap_en    = GAP_CYC != 0;
    assign w_last      = r_sel == SW'(N_DIGITS - 1);
    assign w_show_done = r_state == ST_SHOW && w_tmr_done;
    assign w_to_fetch  = r_state == ST_IDLE || (r_state == ST_GAP && w_tmr_done) || (w_show_done && !w_gap_en);
    assign w_new_frame = w_to_fetch && (r_state == ST_IDLE || w_last);
    assign w_tmr_load  = r_state == ST_LOAD || (w_show_done && w_gap_en);
    assign w_tmr_val   = (r_state == ST_LOAD) ? TW'(SHOW_CYC) : TW'(GAP_CYC);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  w_state_nxt = ST_FETCH;
            ST_FETCH: w_state_nxt = ST_LOAD;
            ST_LOAD:  w_state_nxt = ST_SHOW;
            ST_SHOW:  w_state_nxt = w_tmr_done ? (w_gap_en ? ST_GAP : ST_FETCH) : ST_SHOW;
            ST_GAP:   w_state_nxt = w_tmr_done ? ST_FETCH : ST_GAP;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // an and sseg always change on the same edge, so a lit anode never sees a stale pattern
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_sel        <= '0;
            r_snap_hex   <= '0;
            r_snap_dp    <= '0;
            r_snap_blank <= '0;
            r_an         <= '1;
            r_sseg       <= SSEG_OFF;
            r_frame_tick <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_frame_tick <= w_show_done && w_last;
            if (w_to_fetch) r_sel <= w_new_frame ? '0 : r_sel + 1'b1;
            if (w_new_frame) begin
                r_snap_hex   <= hex_in;
                r_snap_dp    <= dp_in;
                r_snap_blank <= blank_in;
            end
            if (r_state == ST_LOAD) begin
                r_sseg <= r_snap_blank[r_sel] ? SSEG_OFF : {~r_snap_dp[r_sel], rom_data};
                r_an   <= r_snap_blank[r_sel] ? '1 : ~(N_DIGITS'(1) << r_sel);
            end else if (w_show_done && w_gap_en) begin
                r_sseg <= SSEG_OFF;
                r_an   <= '1;
            end
        end
    end

    led_mux_scan_ctrl_timer #(.TW(TW)) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_done     (w_tmr_done)
    );

    assign rom_addr   = r_snap_hex[4*r_sel +: 4];
    assign an         = r_an;
    assign sseg       = r_sseg;
    assign frame_tick = r_frame_tick;
endmodule

// File: tb/tb_led_mux_scan_ctrl.sv
// tb_led_mux_scan_ctrl: table-driven frame checks with a per-digit scoreboard, plus
// reset-mid-frame and zero-gap sequences on a second instance.
module tb_led_mux_scan_ctrl;
    typedef struct packed {
        logic [3:0] an;
        logic [7:0] sseg;
    } exp_t;

    typedef struct packed {
        logic [15:0]     hex;
        logic [3:0]      dp;
        logic [3:0]      blank;
        logic [3:0][3:0] an;
        logic [3:0][7:0] sseg;
    } vec_t;

    localparam int NV = 6;

    logic        clk = 1'b0, reset_n = 1'b0, reset0_n = 1'b0;
    logic [15:0] hex_in = '0;
    logic [3:0]  dp_in = '0, blank_in = '0;
    logic [3:0]  rom_addr, rom_addr0, an, an0;
    logic [6:0]  rom_data = '0, rom_data0 = '0;
    logic [7:0]  sseg, sseg0;
    logic        frame_tick, frame_tick0;
    logic        pt = 1'b0, pt0 = 1'b0;

    vec_t tbl [NV];
    exp_t sb [$];
    logic [7:0] s3210 [4] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0};
    int n_tests = 0, n_fail = 0;

    led_mux_scan_ctrl #(.N_DIGITS(4), .SHOW_CYC(4), .GAP_CYC(2)) dut (
        .clk(clk), .reset_n(reset_n), .hex_in(hex_in), .dp_in(dp_in), .blank_in(blank_in),
        .rom_addr(rom_addr), .rom_data(rom_data), .an(an), .sseg(sseg), .frame_tick(frame_tick)
    );

    led_mux_scan_ctrl #(.N_DIGITS(4), .SHOW_CYC(4), .GAP_CYC(0)) dut0 (
        .clk(clk), .reset_n(reset0_n), .hex_in(hex_in), .dp_in(dp_in), .blank_in(blank_in),
        .rom_addr(rom_addr0), .rom_data(rom_data0), .an(an0), .sseg(sseg0), .frame_tick(frame_tick0)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [7:0] pat(input logic [3:0] h);
        case (h)
            4'h0: return 8'hC0; 4'h1: return 8'hF9; 4'h2: return 8'hA4; 4'h3: return 8'hB0;
            4'h4: return 8'h99; 4'h5: return 8'h92; 4'h6: return 8'h82; 4'h7: return 8'hF8;
            4'h8: return 8'h80; 4'h9: return 8'h90; 4'hA: return 8'h88; 4'hB: return 8'h83;
            4'hC: return 8'hC6; 4'hD: return 8'hA1; 4'hE: return 8'h86; default: return 8'h8E;
        endcase
    endfunction

    // one-cycle-latency pattern ROM models
    always @(posedge clk) begin
        rom_data  <= 7'(pat(rom_addr));
        rom_data0 <= 7'(pat(rom_addr0));
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic apply(input int v);
        hex_in   = tbl[v].hex;
        dp_in    = tbl[v].dp;
        blank_in = tbl[v].blank;
        for (int d = 0; d < 4; d++) sb.push_back('{tbl[v].an[d], tbl[v].sseg[d]});
    endtask

    always @(negedge clk) begin
        chk("an_onehot", 8'($countones(~an) <= 1), 8'd1);
        chk("an0_onehot", 8'($countones(~an0) <= 1), 8'd1);
        chk("tick_pair", {7'd0, frame_tick & pt}, 8'd0);
        chk("tick0_pair", {7'd0, frame_tick0 & pt0}, 8'd0);
        pt  = frame_tick;
        pt0 = frame_tick0;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t       e;
        logic [3:0] ea;
        logic [7:0] es;
        int         d, q;
        tbl[0] = '{16'h3210, 4'b0000, 4'b0000, {4'b0111, 4'b1011, 4'b1101, 4'b1110}, {8'hB0, 8'hA4, 8'hF9, 8'hC0}};
        tbl[1] = '{16'hFFFF, 4'b0000, 4'b0000, {4'b0111, 4'b1011, 4'b1101, 4'b1110}, {8'h8E, 8'h8E, 8'h8E, 8'h8E}};
        tbl[2] = '{16'h3210, 4'b0100, 4'b0001, {4'b0111, 4'b1011, 4'b1101, 4'b1111}, {8'hB0, 8'h24, 8'hF9, 8'hFF}};
        tbl[3] = '{16'h8A5C, 4'b1001, 4'b0000, {4'b0111, 4'b1011, 4'b1101, 4'b1110}, {8'h00, 8'h88, 8'h92, 8'h46}};
        tbl[4] = '{16'h0000, 4'b1111, 4'b1111, {4'b1111, 4'b1111, 4'b1111, 4'b1111}, {8'hFF, 8'hFF, 8'hFF, 8'hFF}};
        tbl[5] = '{16'h3210, 4'b0000, 4'b0000, {4'b0111, 4'b1011, 4'b1101, 4'b1110}, {8'hB0, 8'hA4, 8'hF9, 8'hC0}};
        e = '0;
        apply(0);
        repeat (3) @(negedge clk);
        chk("rst_an", {4'h0, an}, 8'h0F);
        chk("rst_sseg", sseg, 8'hFF);
        chk("rst_tick", {7'd0, frame_tick}, 8'd0);
        chk("rst_addr", {4'h0, rom_addr}, 8'd0);
        reset_n = 1'b1;
        // next vector is applied while digit 1 shows, so every frame also checks snapshot isolation
        for (int v = 0; v < NV; v++)
            for (int dd = 0; dd < 4; dd++)
                for (int qq = 0; qq < 8; qq++) begin
                    @(negedge clk);
                    if (qq == 2) begin
                        chk($sformatf("v%0d d%0d sb_nonempty", v, dd), 8'(sb.size() != 0), 8'd1);
                        if (sb.size() != 0) e = sb.pop_front();
                    end
                    ea = (qq >= 2 && qq <= 5) ? e.an : 4'hF;
                    es = (qq >= 2 && qq <= 5) ? e.sseg : 8'hFF;
                    chk($sformatf("v%0d d%0d q%0d an", v, dd, qq), {4'h0, an}, {4'h0, ea});
                    chk($sformatf("v%0d d%0d q%0d sseg", v, dd, qq), sseg, es);
                    chk($sformatf("v%0d d%0d q%0d tick", v, dd, qq), {7'd0, frame_tick}, 8'(dd == 3 && qq == 6));
                    if (qq == 0)
                        chk($sformatf("v%0d d%0d addr", v, dd), {4'h0, rom_addr}, 8'((tbl[v].hex >> (4 * dd)) & 16'hF));
                    if (dd == 1 && qq == 2 && v + 1 < NV) apply(v + 1);
                end
        repeat (19) @(negedge clk);
        chk("mid_show_an", {4'h0, an}, 8'h0B);
        chk("mid_show_sseg", sseg, 8'hA4);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_an", {4'h0, an}, 8'h0F);
        chk("async_rst_sseg", sseg, 8'hFF);
        chk("async_rst_tick", {7'd0, frame_tick}, 8'd0);
        chk("async_rst_addr", {4'h0, rom_addr}, 8'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rescan_fetch_addr", {4'h0, rom_addr}, 8'd0);
        chk("rescan_fetch_an", {4'h0, an}, 8'h0F);
        repeat (2) @(negedge clk);
        chk("rescan_d0_an", {4'h0, an}, 8'h0E);
        chk("rescan_d0_sseg", sseg, 8'hC0);
        reset0_n = 1'b1;
        for (int c = 0; c < 48; c++) begin
            @(negedge clk);
            d = (c / 6) % 4;
            q = c % 6;
            if (q >= 2) begin
                ea = ~(4'b0001 << d);
                es = s3210[d];
            end else if (c < 6) begin
                ea = 4'hF;
                es = 8'hFF;
            end else begin
                ea = ~(4'b0001 << ((d + 3) % 4));
                es = s3210[(d + 3) % 4];
            end
            chk($sformatf("g0 c%0d an", c), {4'h0, an0}, {4'h0, ea});
            chk($sformatf("g0 c%0d sseg", c), sseg0, es);
            chk($sformatf("g0 c%0d tick", c), {7'd0, frame_tick0}, 8'(q == 0 && d == 0 && c >= 6));
            if (q == 0) chk($sformatf("g0 c%0d addr", c), {4'h0, rom_addr0}, 8'(d));
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
